loopback_msg_hdr_inserter: RTL
==============================

# loopback_msg_hdr_inserter

Prepends the 64-bit loopback destination header to each core-to-core message frame, on the path upstream of the loopback message FIFO's header remover. One instance per loopback port. The 64-bit header is merged into the stream as a 64-bit left shift of the payload, so the downstream remover can strip it with ALWAYS_HDR set. The header carries the frame's destination ID tag and a per-instance sequence number.

## Interface
- DATA_WIDTH, 64: stream width in bits; must be a multiple of 64 and at least 64.
- STRB_WIDTH, DATA_WIDTH/8: tkeep width.
- CORE_WIDTH, 4: core index width.
- ID_TAG_WIDTH, 5+CORE_WIDTH: destination tag width; must be at most 32.
- clk  in  1  sole clock.
- rst_n  in  1  reset, synchronous and active-low.
- s_axis_tdata  in  DATA_WIDTH  payload.
- s_axis_tkeep  in  STRB_WIDTH  byte enables; contiguous from bit 0.
- s_axis_tvalid  in  1  payload valid.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tdest  in  ID_TAG_WIDTH  destination tag; sampled on the frame's first beat only.
- s_axis_tready  out  1  payload accepted.
- m_axis_tdata / tkeep / tvalid / tlast  out  DATA_WIDTH / STRB_WIDTH / 1 / 1  framed stream.
- m_axis_tready  in  1  downstream ready.
- frame_count  out  16  count of frames completed on the output (tlast handshakes); wraps.

## Operation
- Header layout:
  - [ID_TAG_WIDTH-1:0] = tdest of the frame's first beat.
  - [31:ID_TAG_WIDTH] = 0.
  - [47:32] = seq.
  - [63:48] = 16'h0000.
- seq is a 16-bit counter, 0 after reset. It increments on the handshake of each frame's first input beat and wraps 0xFFFF→0.
- Carry register: 64 data bits plus 8 keep bits. It holds the top 64 bits of the previous input beat.
- Output beat = {in[DATA_WIDTH-65:0], carry}; keep = {in_keep[STRB_WIDTH-9:0], carry_keep}.
  - When DATA_WIDTH==64, the input part is empty and the output beat is the carry alone.
- FSM states:
  - FIRST: the carry source is the header with keep 8'hFF.
  - BODY: the carry source is the carry register.
  - FLUSH: output = {0, carry}, keep = {0, carry_keep}, tlast=1. No input is consumed; s_axis_tready=0.
- On an input handshake in FIRST or BODY:
  - Carry register ← in[DATA_WIDTH-1:DATA_WIDTH-64] and in_keep top 8 bits.
  - If !tlast: state ← BODY, output tlast=0.
  - If tlast and the incoming top 8 keep bits == 0: output tlast=1, state ← FIRST.
  - If tlast and the incoming top 8 keep bits != 0: output tlast=0, state ← FLUSH.
  - With DATA_WIDTH==64, every frame ends through FLUSH.
- FLUSH → FIRST when its beat is loaded into the output register.

## Timing
- Output is a single registered stage.
- s_axis_tready = (state != FLUSH) && (!m_axis_tvalid || m_axis_tready).
- Output register loads on an input handshake, or on entering/draining FLUSH under the same enable.
- Latency: input handshake → m_axis_tvalid one cycle later.
- Throughput:
  - One beat per cycle within a frame.
  - One bubble input cycle per frame only when FLUSH is needed.
  - Back-to-back frames need no idle cycle otherwise.
- Output holds stable while tvalid && !tready.
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0, s_axis_tready=0 during reset, state=FIRST, seq=0, frame_count=0, carry=0.
- Reset mid-frame: the partial frame is discarded with no tlast emitted. The upstream source is reset in the same domain.
- A FLUSH beat and the next frame's first beat never share a cycle.

## Structure
- Shared package (loopback_pkg):
  - HDR_WIDTH=64.
  - Header field offsets: TAG_LSB=0, SEQ_LSB=32, SEQ_WIDTH=16.
  - FSM state encoding: FIRST, BODY, FLUSH.
- No sub-module: shift, FSM and output register fit in one module of about 200 lines.

## Test plan
- DATA_WIDTH=64; frame of 3 full beats, tdest=0x1A5 → 4 output beats:
  - beat0 = 0x0000_0000_0000_01A5, keep 0xFF.
  - Beats 1–3 equal the inputs; tlast on beat3 only.
  - The next frame's header has [47:32]=0x0001.
- DATA_WIDTH=128; 2-beat frame, last keep 0x00FF → 2 output beats, no FLUSH:
  - beat0 = {in0[63:0], header}.
  - Last beat keep 0xFFFF, tlast=1.
- DATA_WIDTH=128; 2-beat frame, last keep 0xFFFF → 3 output beats; FLUSH beat keep 0x00FF, tlast=1.
- Random m_axis_tready at 30% duty over 100 random frames → byte-exact match against a reference model, and frame_count == 100.
- Force seq to 0xFFFF, send 2 frames → header seq fields 0xFFFF then 0x0000.
- Assert rst_n=0 for 1 cycle mid-frame → m_axis_tvalid=0 next cycle; next frame header seq=0, tag correct.

Source files
------------

// File: rtl/loopback_msg_hdr_inserter_pkg.sv
// Shared definitions for the loopback message path: header geometry, field
// offsets, inserter FSM encoding and the header builder.
package loopback_pkg;

  localparam int HDR_WIDTH      = 64;
  localparam int HDR_KEEP_WIDTH = HDR_WIDTH / 8;
  localparam int TAG_LSB        = 0;
  localparam int SEQ_LSB        = 32;
  localparam int SEQ_WIDTH      = 16;

  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_BODY  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Tag arrives zero-extended to 32 bits; bits [63:48] stay zero.
  function automatic logic [HDR_WIDTH-1:0] build_header(input logic [31:0]          tag,
                                                        input logic [SEQ_WIDTH-1:0] seq);
    logic [HDR_WIDTH-1:0] hdr;
    hdr                         = '0;
    hdr[TAG_LSB +: 32]          = tag;
    hdr[SEQ_LSB +: SEQ_WIDTH]   = seq;
    return hdr;
  endfunction

endpackage

// File: rtl/loopback_msg_hdr_inserter_if.sv
// AXI-stream style bundle used on both sides of the header inserter.
interface loopback_msg_hdr_inserter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int DEST_WIDTH = 9
);

  logic [DATA_WIDTH-1:0] tdata;
  logic [STRB_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic [DEST_WIDTH-1:0] tdest;
  logic                  tready;

  modport master (output tdata, tkeep, tvalid, tlast, tdest, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tdest, output tready);

endinterface

// File: rtl/loopback_msg_hdr_inserter.sv
// Prepends a 64-bit {seq, dest tag} header to each frame by shifting the
// payload up 64 bits through a carry register, with one registered output.
module loopback_msg_hdr_inserter
  import loopback_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int CORE_WIDTH   = 4,
  parameter int ID_TAG_WIDTH = 5 + CORE_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  loopback_msg_hdr_inserter_if.slave    s_axis,
  loopback_msg_hdr_inserter_if.master   m_axis,
  output logic [15:0]                   frame_count
);

  state_t                    state;
  logic [SEQ_WIDTH-1:0]      seq;
  logic [HDR_WIDTH-1:0]      carry_data;
  logic [HDR_KEEP_WIDTH-1:0] carry_keep;

  logic [DATA_WIDTH-1:0]     out_data;
  logic [STRB_WIDTH-1:0]     out_keep;
  logic                      out_valid;
  logic                      out_last;
  logic [15:0]               frame_cnt;

  logic                      out_en;
  logic                      in_ready;
  logic                      in_fire;
  logic                      out_fire;
  logic [ID_TAG_WIDTH-1:0]   first_tag;
  logic [HDR_WIDTH-1:0]      src_data;
  logic [HDR_KEEP_WIDTH-1:0] src_keep;
  logic [HDR_WIDTH-1:0]      in_top;
  logic [HDR_KEEP_WIDTH-1:0] in_top_keep;
  logic [DATA_WIDTH-1:0]     shift_data;
  logic [STRB_WIDTH-1:0]     shift_keep;
  logic [DATA_WIDTH-1:0]     flush_data;
  logic [STRB_WIDTH-1:0]     flush_keep;

  assign out_en   = !out_valid || m_axis.tready;
  assign in_ready = rst_n && (state != ST_FLUSH) && out_en;
  assign in_fire  = s_axis.tvalid && in_ready;
  assign out_fire = out_valid && m_axis.tready;

  assign first_tag   = s_axis.tdest;
  assign src_data    = (state == ST_FIRST) ? build_header(32'(first_tag), seq) : carry_data;
  assign src_keep    = (state == ST_FIRST) ? {HDR_KEEP_WIDTH{1'b1}} : carry_keep;
  assign in_top      = s_axis.tdata[DATA_WIDTH-1 -: HDR_WIDTH];
  assign in_top_keep = s_axis.tkeep[STRB_WIDTH-1 -: HDR_KEEP_WIDTH];
  assign flush_data  = DATA_WIDTH'(carry_data);
  assign flush_keep  = STRB_WIDTH'(carry_keep);

  // A 64-bit stream has no room beside the carry, so its output is the carry alone.
  generate
    if (DATA_WIDTH == HDR_WIDTH) begin : g_narrow
      assign shift_data = src_data;
      assign shift_keep = src_keep;
    end else begin : g_wide
      assign shift_data = {s_axis.tdata[DATA_WIDTH-HDR_WIDTH-1:0], src_data};
      assign shift_keep = {s_axis.tkeep[STRB_WIDTH-HDR_KEEP_WIDTH-1:0], src_keep};
    end
  endgenerate

  // Frame FSM, carry, sequence counter and output register share one enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_FIRST;
      seq        <= '0;
      carry_data <= '0;
      carry_keep <= '0;
      out_data   <= '0;
      out_keep   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      if (out_fire) begin
        out_valid <= 1'b0;
        if (out_last) begin
          frame_cnt <= frame_cnt + 16'd1;
        end
      end

      if (in_fire) begin
        out_data   <= shift_data;
        out_keep   <= shift_keep;
        out_valid  <= 1'b1;
        carry_data <= in_top;
        carry_keep <= in_top_keep;
        if (state == ST_FIRST) begin
          seq <= seq + SEQ_WIDTH'(1);
        end
        if (!s_axis.tlast) begin
          out_last <= 1'b0;
          state    <= ST_BODY;
        end else if (in_top_keep == '0) begin
          out_last <= 1'b1;
          state    <= ST_FIRST;
        end else begin
          out_last <= 1'b0;
          state    <= ST_FLUSH;
        end
      end else if ((state == ST_FLUSH) && out_en) begin
        // Leftover top bytes of the last beat go out alone as the closing beat.
        out_data  <= flush_data;
        out_keep  <= flush_keep;
        out_last  <= 1'b1;
        out_valid <= 1'b1;
        state     <= ST_FIRST;
      end
    end
  end

  assign s_axis.tready = in_ready;
  assign m_axis.tdata  = out_data;
  assign m_axis.tkeep  = out_keep;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tlast  = out_last;
  assign m_axis.tdest  = '0;
  assign frame_count   = frame_cnt;

endmodule
